// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - FSM state encoding and requester-count bounds for the shared multiplier arbiter
package mult_share_pkg;

  // Legal range for the number of requesters sharing one multiplier
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  // Arbiter FSM: pick an owner, kick the multiplier, wait for it, hand back the result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick_taint.sv
// rtl/rr_pick_taint.sv - round-robin requester pick starting at a pointer, with decision taint
module rr_pick_taint #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_req_t,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [PW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot,
  output logic            o_taint
);

  // Requester index k positions after the pointer, wrapping at NREQ
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest request at/after the pointer wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[rot(i_ptr, k)]) begin
        o_valid = 1'b1;
        o_idx   = rot(i_ptr, k);
      end
    end
    o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;
  end

  // Who wins depends on every request line, so any tainted request taints the decision
  assign o_taint = |i_req_t;

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one multiplier; optional MULT_SHARE_STATE_TAINT_EN adds sticky state taint
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_t,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_a_t,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  input  logic [NREQ*WIDTH-1:0]   op_b_t,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         gnt_t,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ-1:0]         rsp_valid_t,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic [2*WIDTH-1:0]      rsp_product_t,
  output logic                    m_start,
  output logic                    m_start_t,
  output logic [WIDTH-1:0]        m_multiplier,
  output logic [WIDTH-1:0]        m_multiplier_t,
  output logic [WIDTH-1:0]        m_multiplicand,
  output logic [WIDTH-1:0]        m_multiplicand_t,
  input  logic [2*WIDTH-1:0]      m_product,
  input  logic [2*WIDTH-1:0]      m_product_t,
  input  logic                    m_done,
  input  logic                    m_done_t
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreq_range
    $error("mult_share_arbiter: NREQ out of range");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_grant_en;
  logic               w_done_en;
  logic               w_resp_en;
  logic               w_pick_valid;
  logic               w_pick_t;
  logic [PW-1:0]      w_pick_idx;
  logic [NREQ-1:0]    w_pick_onehot;
  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      r_owner;
  logic               r_owner_t;
  logic               r_done_t;
  logic               r_gnt_t;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_rsp_valid;
  logic [WIDTH-1:0]   r_op_a, r_op_a_t, r_op_b, r_op_b_t;
  logic [2*WIDTH-1:0] r_product, r_product_t;
  logic               w_ctl_t;
  logic [WIDTH-1:0]   w_a [NREQ];
  logic [WIDTH-1:0]   w_a_t [NREQ];
  logic [WIDTH-1:0]   w_b [NREQ];
  logic [WIDTH-1:0]   w_b_t [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_a[g]   = op_a[g*WIDTH +: WIDTH];
    assign w_a_t[g] = op_a_t[g*WIDTH +: WIDTH];
    assign w_b[g]   = op_b[g*WIDTH +: WIDTH];
    assign w_b_t[g] = op_b_t[g*WIDTH +: WIDTH];
  end

  rr_pick_taint #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req    (req),
    .i_req_t  (req_t),
    .i_ptr    (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot),
    .o_taint  (w_pick_t)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and single-cycle datapath enables; m_done outside WAIT is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_done_en   = 1'b0;
    w_resp_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (m_done) begin
          w_done_en   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp_en   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant capture, result capture and response pulse; operands are frozen at grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt       <= '0;
      r_gnt_t     <= 1'b0;
      r_rsp_valid <= '0;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_owner_t   <= 1'b0;
      r_done_t    <= 1'b0;
      r_op_a      <= '0;
      r_op_a_t    <= '0;
      r_op_b      <= '0;
      r_op_b_t    <= '0;
      r_product   <= '0;
      r_product_t <= '0;
    end else begin
      r_gnt       <= '0;
      r_gnt_t     <= 1'b0;
      r_rsp_valid <= '0;
      if (w_grant_en) begin
        r_gnt     <= w_pick_onehot;
        r_gnt_t   <= w_pick_t;
        r_owner   <= w_pick_idx;
        r_owner_t <= w_pick_t;
        r_done_t  <= 1'b0;
        r_op_a    <= w_a[w_pick_idx];
        r_op_a_t  <= w_a_t[w_pick_idx];
        r_op_b    <= w_b[w_pick_idx];
        r_op_b_t  <= w_b_t[w_pick_idx];
      end
      if (w_done_en) begin
        r_product   <= m_product;
        r_product_t <= m_product_t;
        r_done_t    <= m_done_t;
      end
      if (w_resp_en) begin
        r_rsp_valid <= NREQ'(1) << r_owner;
        r_rr_ptr    <= (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
      end
    end
  end

`ifdef MULT_SHARE_STATE_TAINT_EN
  logic r_state_t;

  // Sticky taint: once a tainted grant or done steers the FSM, control stays tainted until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   r_state_t <= 1'b0;
    else if ((w_grant_en && w_pick_t) || (w_done_en && m_done_t)) r_state_t <= 1'b1;
  end

  assign w_ctl_t = r_state_t;
`else
  assign w_ctl_t = 1'b0;
`endif

  assign gnt              = r_gnt;
  assign gnt_t            = {NREQ{r_gnt_t | w_ctl_t}};
  assign rsp_valid        = r_rsp_valid;
  assign rsp_valid_t      = {NREQ{r_owner_t | r_done_t | w_ctl_t}};
  assign rsp_product      = r_product;
  assign rsp_product_t    = r_product_t;
  assign m_start          = (r_state == ST_ISSUE);
  assign m_start_t        = r_owner_t | w_ctl_t;
  assign m_multiplier     = r_op_a;
  assign m_multiplier_t   = r_op_a_t;
  assign m_multiplicand   = r_op_b;
  assign m_multiplicand_t = r_op_b_t;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized self-checking bench for mult_share_arbiter against a transaction-level model
module tb_mult_share_arbiter;

  localparam int W = 16;
  localparam int N = 3;
`ifdef MULT_SHARE_STATE_TAINT_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, req_t, gnt, gnt_t, rsp_valid, rsp_valid_t;
  logic [N*W-1:0] op_a, op_a_t, op_b, op_b_t;
  logic [2*W-1:0] rsp_product, rsp_product_t, m_product, m_product_t;
  logic m_start, m_start_t, m_done, m_done_t;
  logic [W-1:0] m_multiplier, m_multiplier_t, m_multiplicand, m_multiplicand_t;

  int n_checks = 0;
  int n_errors = 0;

  // model state: per-requester pending flag and operands, arbiter pointer, sticky taint
  bit           pend [N];
  logic [W-1:0] a [N], b [N], ta [N], tb [N];
  logic [N-1:0] rt;
  int           ptr;
  bit           st;
  bit           force_dt;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_t(req_t),
    .op_a(op_a), .op_a_t(op_a_t), .op_b(op_b), .op_b_t(op_b_t),
    .gnt(gnt), .gnt_t(gnt_t),
    .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t),
    .rsp_product(rsp_product), .rsp_product_t(rsp_product_t),
    .m_start(m_start), .m_start_t(m_start_t),
    .m_multiplier(m_multiplier), .m_multiplier_t(m_multiplier_t),
    .m_multiplicand(m_multiplicand), .m_multiplicand_t(m_multiplicand_t),
    .m_product(m_product), .m_product_t(m_product_t),
    .m_done(m_done), .m_done_t(m_done_t)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    a[i]    = W'($urandom);
    b[i]    = W'($urandom);
    ta[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom & $urandom) : '0;
    tb[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom & $urandom) : '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]             = pend[i];
      op_a[i*W +: W]     = a[i];
      op_a_t[i*W +: W]   = ta[i];
      op_b[i*W +: W]     = b[i];
      op_b_t[i*W +: W]   = tb[i];
    end
    req_t = rt;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    m_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
    st  = 1'b0;
  endtask

  // IDLE cycles with no requests, optionally with a stray m_done
  task automatic idle_gap(input int k, input bit force_done);
    req = '0;
    for (int c = 0; c < k; c++) begin
      m_done    = force_done ? 1'b1 : 1'($urandom_range(0, 1));
      m_done_t  = 1'b0;
      m_product = 2*W'($urandom);
      @(posedge clk); #1;
      check("idle_gnt", gnt, '0);
      check("idle_m_start", m_start, 0);
      check("idle_rsp_valid", rsp_valid, '0);
    end
    m_done = 1'b0;
  endtask

  // One arbitration round, from request through response (or reset while waiting)
  task automatic do_txn(input bit rnd, input bit hold, input bit rst_wait, output int won);
    int w, d;
    bit tg, dt;
    logic [2*W-1:0] prod, pt;
    bit any;
    if (rnd) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      rt = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!any) new_req($urandom_range(0, N - 1));
    end
    drive_inputs();
    m_done = 1'b0; m_done_t = 1'b0;
    w = pick();
    won = w;
    tg = |rt;
    prod = (2*W)'(a[w]) * (2*W)'(b[w]);
    @(posedge clk); #1;
    if (ST_EN && tg) st = 1'b1;
    check("gnt", gnt, N'(1) << w);
    check("gnt_t", gnt_t, {N{tg | st}});
    check("m_start", m_start, 1);
    check("m_start_t", m_start_t, tg | st);
    check("m_multiplier", m_multiplier, a[w]);
    check("m_multiplier_t", m_multiplier_t, ta[w]);
    check("m_multiplicand", m_multiplicand, b[w]);
    check("m_multiplicand_t", m_multiplicand_t, tb[w]);
    check("grant_rsp_valid", rsp_valid, '0);
    // the winner's request is consumed; its slice changes so capture-at-grant is exercised
    if (!hold) begin
      pend[w] = 1'b0;
      if (rnd && $urandom_range(0, 2) == 0) new_req(w);
      else begin a[w] = W'($urandom); b[w] = W'($urandom); end
    end
    drive_inputs();
    m_done    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    m_product = 2*W'($urandom);
    @(posedge clk); #1;
    m_done = 1'b0;
    if (rst_wait) begin
      rst = 1'b1; #1;
      check("rst_gnt", gnt, '0);
      check("rst_gnt_t", gnt_t, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_valid_t", rsp_valid_t, '0);
      check("rst_m_start", m_start, 0);
      check("rst_m_start_t", m_start_t, 0);
      check("rst_rsp_product", rsp_product, '0);
      check("rst_m_multiplier", m_multiplier, '0);
      rst = 1'b0;
      ptr = 0;
      st  = 1'b0;
      return;
    end
    d = rnd ? $urandom_range(0, 3) : 1;
    for (int c = 0; c < d; c++) begin
      check("wait_m_start", m_start, 0);
      check("wait_rsp_valid", rsp_valid, '0);
      @(posedge clk); #1;
    end
    pt = rnd ? 2*W'($urandom) : '0;
    dt = force_dt ? 1'b1 : (rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
    m_done = 1'b1; m_product = prod; m_product_t = pt; m_done_t = dt;
    @(posedge clk); #1;
    if (ST_EN && dt) st = 1'b1;
    m_done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    m_done_t = 1'b0;
    m_product = 2*W'($urandom);
    check("resp_rsp_valid_early", rsp_valid, '0);
    check("resp_product", rsp_product, prod);
    @(posedge clk); #1;
    m_done = 1'b0;
    check("rsp_valid", rsp_valid, N'(1) << w);
    check("rsp_valid_t", rsp_valid_t, {N{tg | dt | st}});
    check("rsp_product", rsp_product, prod);
    check("rsp_product_t", rsp_product_t, pt);
    check("rsp_gnt", gnt, '0);
    ptr = (w + 1) % N;
  endtask

  initial begin
    int won;
    int seq [3];
    rst = 1'b1;
    req = '0; req_t = '0; op_a = '0; op_a_t = '0; op_b = '0; op_b_t = '0;
    m_product = '0; m_product_t = '0; m_done = 1'b0; m_done_t = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; a[i] = '0; b[i] = '0; ta[i] = '0; tb[i] = '0;
    end
    rt = '0; ptr = 0; st = 1'b0; force_dt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", gnt, '0);
    check("reset_gnt_t", gnt_t, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_valid_t", rsp_valid_t, '0);
    check("reset_rsp_product", rsp_product, '0);
    check("reset_rsp_product_t", rsp_product_t, '0);
    check("reset_m_start", m_start, 0);
    check("reset_m_start_t", m_start_t, 0);
    check("reset_m_multiplier", m_multiplier, '0);
    check("reset_m_multiplicand_t", m_multiplicand_t, '0);
    rst = 1'b0;

    // single untainted request 3*5
    pend[0] = 1'b1; a[0] = 16'd3; b[0] = 16'd5;
    do_txn(1'b0, 1'b0, 1'b0, won);
    check("single_product", rsp_product, 32'd15);

    // stray m_done while idle
    idle_gap(3, 1'b1);

    // two requesters held high from pointer 0
    apply_reset();
    new_req(0); new_req(1);
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b0, 1'b1, 1'b0, won);
      seq[k] = won;
    end
    check("rr_first", seq[0], 0);
    check("rr_second", seq[1], 1);
    check("rr_third", seq[2], 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // taint on a non-granted requester's request line
    new_req(0); rt = 3'b010;
    do_txn(1'b0, 1'b0, 1'b0, won);
    rt = '0;

    // single tainted operand bit
    new_req(0); ta[0] = 16'h0001; tb[0] = '0;
    do_txn(1'b0, 1'b0, 1'b0, won);

    // reset while waiting for the multiplier, then restart from pointer 0
    new_req(1);
    do_txn(1'b0, 1'b0, 1'b1, won);
    new_req(0); new_req(2);
    do_txn(1'b0, 1'b0, 1'b0, won);
    check("post_reset_winner", won, 0);

    // tainted m_done, then an untainted round afterwards
    force_dt = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0, won);
    force_dt = 1'b0;
    new_req(1); ta[1] = '0; tb[1] = '0;
    do_txn(1'b0, 1'b0, 1'b0, won);

    // randomized traffic
    apply_reset();
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 4) == 0) idle_gap($urandom_range(1, 3), 1'b0);
      do_txn(1'b1, 1'b0, ($urandom_range(0, 19) == 0), won);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
